calc_sequencer: RTL

Clocked sequencer for the calculator datapath. It synchronises the enter button, captures operands A and B from the input value bus, and issues one operation to the shared multi-cycle ALU over a start/done handshake. It then holds the result for display and optionally chains it as the next A operand. Sits between the board I/O (buttons, switch, LEDs, display mux select) and the ALU.

---
 rtl/calc_seq_pkg.sv | 51 +++++
 rtl/calc_sequencer_button_sync.sv | 37 +++
 rtl/calc_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/calc_seq_pkg.sv
// rtl/calc_seq_pkg.sv - shared encodings for the calculator sequencer
`timescale 1ns/1ps

package calc_seq_pkg;

    // Sequencer state encoding
    localparam logic [2:0] ST_GET_A  = 3'd0;
    localparam logic [2:0] ST_GET_B  = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_SHOW   = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    // ALU opcodes
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Display mux select codes
    localparam logic [1:0] DISP_A    = 2'b00;
    localparam logic [1:0] DISP_B    = 2'b01;
    localparam logic [1:0] DISP_EXEC = 2'b10;
    localparam logic [1:0] DISP_SHOW = 2'b11;

    // Status LED patterns
    localparam logic [9:0] LED_GET_A = 10'b0000000001;
    localparam logic [9:0] LED_GET_B = 10'b0000000010;
    localparam logic [9:0] LED_EXEC  = 10'b0000000100;
    localparam logic [9:0] LED_SHOW  = 10'b0000001000;
    localparam logic [9:0] LED_ERROR = 10'b1111111111;

    typedef struct packed {
        logic [1:0] disp;
        logic [9:0] led;
    } status_t;

    // Board-facing status for a given state; ERROR keeps the EXEC display
    // so the operands that failed stay visible.
    function automatic status_t status_for_state(input logic [2:0] st);
        status_t s;
        case (st)
            ST_GET_B: s = '{disp: DISP_B,    led: LED_GET_B};
            ST_EXEC:  s = '{disp: DISP_EXEC, led: LED_EXEC};
            ST_SHOW:  s = '{disp: DISP_SHOW, led: LED_SHOW};
            ST_ERROR: s = '{disp: DISP_EXEC, led: LED_ERROR};
            default:  s = '{disp: DISP_A,    led: LED_GET_A};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/calc_sequencer_button_sync.sv
// rtl/calc_sequencer_button_sync.sv - enter button synchroniser and rising-edge detector
`timescale 1ns/1ps

module button_sync (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic enter_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    // Shift the raw level through two metastability flops and a history flop
    always_comb begin
        sync1_d = button_raw;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // All flops reset high so a button held through reset never looks like a press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign enter_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator operand/issue sequencer; CALC_CHAIN_EN chains result into A
`timescale 1ns/1ps

module calc_sequencer #(
    parameter int DATA_W      = 40,
    parameter int ALU_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enter_button,
    input  logic              enable_switch,
    input  logic [1:0]        op_sel,
    input  logic [DATA_W-1:0] in_val,
    output logic              alu_start,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic              alu_err,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic [1:0]        display_sel,
    output logic [9:0]        led
);

    import calc_seq_pkg::*;

    localparam int              CNT_W     = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ALU_TIMEOUT);

    logic enter_pulse;
    logic press;

    button_sync u_button_sync (
        .clk         (clk),
        .reset       (reset),
        .button_raw  (enter_button),
        .enter_pulse (enter_pulse)
    );

    assign press = enter_pulse & enable_switch;

    logic [2:0]        state_q,     state_d;
    logic [DATA_W-1:0] alu_a_q,     alu_a_d;
    logic [DATA_W-1:0] alu_b_q,     alu_b_d;
    logic [1:0]        alu_op_q,    alu_op_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic              alu_start_q, alu_start_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              busy_q,      busy_d;
    logic [1:0]        disp_q,      disp_d;
    logic [9:0]        led_q,       led_d;
    logic [CNT_W-1:0]  cnt_inc;
    status_t           status_d;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Sequencer FSM: operand capture, ALU issue, watchdog and result capture
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        alu_start_d = 1'b0;
        case (state_q)
            ST_GET_A: begin
                if (press) begin
                    alu_a_d = in_val;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (press) begin
                    alu_b_d     = in_val;
                    alu_op_d    = op_sel;
                    cnt_d       = '0;
                    alu_start_d = 1'b1;
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Presses are dropped here; a done on the last watchdog cycle still wins
                cnt_d = cnt_inc;
                if (alu_done) begin
                    if (alu_err) begin
                        state_d = ST_ERROR;
                    end else begin
                        result_d = alu_result;
                        state_d  = ST_SHOW;
                    end
                end else if (cnt_inc == CNT_LIMIT) begin
                    state_d = ST_ERROR;
                end
            end
            ST_SHOW: begin
                if (press) begin
`ifdef CALC_CHAIN_EN
                    alu_a_d = result_q;
                    state_d = ST_GET_B;
`else
                    alu_a_d = '0;
                    alu_b_d = '0;
                    state_d = ST_GET_A;
`endif
                end
            end
            ST_ERROR: begin
                if (press) begin
                    alu_a_d = '0;
                    alu_b_d = '0;
                    state_d = ST_GET_A;
                end
            end
            default: begin
                state_d = ST_GET_A;
            end
        endcase
    end

    // Status outputs are decoded from the next state so they register alongside it
    always_comb begin
        status_d = status_for_state(state_d);
        disp_d   = status_d.disp;
        led_d    = status_d.led;
        busy_d   = (state_d == ST_EXEC);
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_GET_A;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_ADD;
            result_q    <= '0;
            alu_start_q <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            disp_q      <= DISP_A;
            led_q       <= LED_GET_A;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            result_q    <= result_d;
            alu_start_q <= alu_start_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            disp_q      <= disp_d;
            led_q       <= led_d;
        end
    end

    assign alu_start   = alu_start_q;
    assign alu_op      = alu_op_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign result      = result_q;
    assign busy        = busy_q;
    assign display_sel = disp_q;
    assign led         = led_q;

endmodule
